// File: rtl/hz_pkg.sv
// hz_pkg: shared types and constants for the hazard scoreboard
package hz_pkg;
    localparam int TNEW_W       = 4;
    localparam int TW_DEF       = 2;
    localparam logic [TW_DEF-1:0] T_UNUSED = '1;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int STG_E        = 1;
    localparam int STG_M        = 2;
    localparam int STG_W        = 3;

    typedef struct packed {
        logic              wen;
        logic [4:0]        dst;
        logic [TNEW_W-1:0] tnew;
        logic              md_start;
    } hz_entry_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? t : t - TNEW_W'(1);
    endfunction
endpackage

// File: rtl/hz_md_counter.sv
// hz_md_counter: HI/LO busy countdown loaded when a mult/div occupies E
module hz_md_counter
    import hz_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);
    localparam int CW = $clog2(imax(MULT_CYC, DIV_CYC) + 1);

    logic [CW-1:0] r_cnt;

    // Reload on a new mult/div in E, otherwise count down to zero and hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_start)
            r_cnt <= i_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end

    assign o_busy = (r_cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall/forward unit with an in-flight destination scoreboard and HI/LO busy tracking
module hazard_scoreboard
    import hz_pkg::*;
#(
    parameter int NSTAGE   = STG_W,
    parameter int TW       = TW_DEF,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int SW       = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic [TW-1:0] d_t_use_rs,
    input  logic [TW-1:0] d_t_use_rt,
    input  logic [4:0]    d_dst,
    input  logic          d_wen,
    input  logic [TW-1:0] d_t_new,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel,
    output logic          fwd_rs_late,
    output logic          fwd_rt_late,
    output logic          md_busy
);
    hz_entry_t r_sb  [1:NSTAGE];
    hz_entry_t w_nxt [1:NSTAGE];
    logic      r_div_e;

    logic [NSTAGE:1] w_hit_rs, w_hit_rt, w_slow_rs, w_slow_rt;
    logic            w_used_rs, w_used_rt, w_data_stall, w_md_stall;
    logic [SW-1:0]   w_rs_k, w_rt_k;
    logic            w_rs_any, w_rt_any, w_rs_rdy, w_rt_rdy;

    assign w_used_rs = (d_rs != 5'd0) && !(&d_t_use_rs);
    assign w_used_rt = (d_rt != 5'd0) && !(&d_t_use_rt);

    for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
        assign w_hit_rs[k]  = w_used_rs && r_sb[k].wen && (r_sb[k].dst == d_rs);
        assign w_hit_rt[k]  = w_used_rt && r_sb[k].wen && (r_sb[k].dst == d_rt);
        assign w_slow_rs[k] = w_hit_rs[k] && (r_sb[k].tnew > TNEW_W'(d_t_use_rs));
        assign w_slow_rt[k] = w_hit_rt[k] && (r_sb[k].tnew > TNEW_W'(d_t_use_rt));
        if (k == 1) begin : g_head
            assign w_nxt[k] = stall ? hz_entry_t'('0)
                                    : hz_entry_t'{wen: d_wen, dst: d_dst, tnew: TNEW_W'(d_t_new), md_start: d_md_start};
        end else begin : g_tail
            assign w_nxt[k] = hz_entry_t'{wen: r_sb[k-1].wen, dst: r_sb[k-1].dst,
                                          tnew: tnew_dec(r_sb[k-1].tnew), md_start: r_sb[k-1].md_start};
        end
    end

    // Shift the scoreboard one stage per cycle; a stalled D slot enters E as a bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sb    <= '{default: '0};
            r_div_e <= 1'b0;
        end else begin
            r_sb    <= w_nxt;
            r_div_e <= !stall && d_md_start && d_md_div;
        end
    end

    // Youngest matching stage per operand; scanning oldest first lets the youngest overwrite
    always_comb begin
        w_rs_any = 1'b0;
        w_rs_k   = '0;
        w_rs_rdy = 1'b0;
        w_rt_any = 1'b0;
        w_rt_k   = '0;
        w_rt_rdy = 1'b0;
        for (int i = NSTAGE; i >= 1; i--) begin
            if (w_hit_rs[i]) begin
                w_rs_any = 1'b1;
                w_rs_k   = SW'(i);
                w_rs_rdy = (r_sb[i].tnew == '0);
            end
            if (w_hit_rt[i]) begin
                w_rt_any = 1'b1;
                w_rt_k   = SW'(i);
                w_rt_rdy = (r_sb[i].tnew == '0);
            end
        end
    end

    assign w_data_stall = |{w_slow_rs, w_slow_rt};
    assign w_md_stall   = d_md_use && (md_busy || r_sb[STG_E].md_start);
    assign stall        = w_data_stall || w_md_stall;

    assign fwd_rs_sel  = (w_rs_any && w_rs_rdy) ? w_rs_k : '0;
    assign fwd_rt_sel  = (w_rt_any && w_rt_rdy) ? w_rt_k : '0;
    assign fwd_rs_late = w_rs_any && !w_rs_rdy && !stall;
    assign fwd_rt_late = w_rt_any && !w_rt_rdy && !stall;

    hz_md_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (r_sb[STG_E].md_start),
        .i_div   (r_div_e),
        .o_busy  (md_busy)
    );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: vector table, reset corner and randomized run against a history-based hazard model
module tb_hazard_scoreboard;
    import hz_pkg::*;

    localparam int NS = 3;
    localparam int MC = 5;
    localparam int DC = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_t_use_rs, d_t_use_rt, d_t_new;
    logic       d_wen, d_md_start, d_md_div, d_md_use;
    logic       stall, fwd_rs_late, fwd_rt_late, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NSTAGE(NS), .TW(2), .MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_t_use_rs  (d_t_use_rs),
        .d_t_use_rt  (d_t_use_rt),
        .d_dst       (d_dst),
        .d_wen       (d_wen),
        .d_t_new     (d_t_new),
        .d_md_start  (d_md_start),
        .d_md_div    (d_md_div),
        .d_md_use    (d_md_use),
        .stall       (stall),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel),
        .fwd_rs_late (fwd_rs_late),
        .fwd_rt_late (fwd_rt_late),
        .md_busy     (md_busy)
    );

    typedef struct {
        logic [4:0] rs, rt, dst;
        logic [1:0] tu_rs, tu_rt, tn;
        logic       wen, mds, mdd, mdu;
        int         x_stall, x_rs_sel, x_rs_late, x_rt_sel, x_rt_late, x_busy;
    } vec_t;

    typedef struct {
        bit       wen;
        bit [4:0] dst;
        int       tnew;
        bit       md;
        bit       div;
    } rec_t;

    rec_t ent [0:2047];
    rec_t bub;
    vec_t cur;
    vec_t tab [$];
    int   cyc;
    int   n_chk, n_err;
    int   m_stall, m_rs_sel, m_rs_late, m_rt_sel, m_rt_late, m_busy;

    function automatic vec_t mk(input int rs, tu_rs, rt, tu_rt, dst, wen, tn, mds, mdd, mdu,
                                input int xs, xrs, xrl, xrt, xtl, xb);
        vec_t v;
        v.rs = 5'(rs); v.tu_rs = 2'(tu_rs); v.rt = 5'(rt); v.tu_rt = 2'(tu_rt);
        v.dst = 5'(dst); v.wen = 1'(wen); v.tn = 2'(tn);
        v.mds = 1'(mds); v.mdd = 1'(mdd); v.mdu = 1'(mdu);
        v.x_stall = xs; v.x_rs_sel = xrs; v.x_rs_late = xrl;
        v.x_rt_sel = xrt; v.x_rt_late = xtl; v.x_busy = xb;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        cur = v;
        d_rs = v.rs; d_rt = v.rt; d_t_use_rs = v.tu_rs; d_t_use_rt = v.tu_rt;
        d_dst = v.dst; d_wen = v.wen; d_t_new = v.tn;
        d_md_start = v.mds; d_md_div = v.mdd; d_md_use = v.mdu;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // The instruction that sat in E k-1 cycles ago is in stage k now, with its t_new aged by k-1
    function automatic void op_eval(input logic [4:0] r, input logic [1:0] tu,
                                    output bit slow, output bit hit, output int sel, output bit rdy);
        rec_t e;
        int   tn;
        slow = 0; hit = 0; sel = 0; rdy = 0;
        if (r != 5'd0 && tu != T_UNUSED) begin
            for (int k = 1; k <= NS; k++) begin
                e  = ent[cyc - k + 1];
                tn = e.tnew - (k - 1);
                if (tn < 0) tn = 0;
                if (e.wen && e.dst == r) begin
                    if (tn > int'(tu)) slow = 1;
                    if (!hit) begin
                        hit = 1; sel = k; rdy = (tn == 0);
                    end
                end
            end
        end
    endfunction

    task automatic model();
        bit s1, h1, r1, s2, h2, r2, busy, found;
        int k1, k2;
        op_eval(cur.rs, cur.tu_rs, s1, h1, k1, r1);
        op_eval(cur.rt, cur.tu_rt, s2, h2, k2, r2);
        busy = 0; found = 0;
        for (int e = cyc - 1; e >= 0 && e >= cyc - DC - 1; e--) begin
            if (!found && ent[e].md) begin
                found = 1;
                busy  = (cyc - e) <= (ent[e].div ? DC : MC);
            end
        end
        m_busy    = busy;
        m_stall   = s1 || s2 || (cur.mdu && (busy || ent[cyc].md));
        m_rs_sel  = (h1 && r1) ? k1 : 0;
        m_rt_sel  = (h2 && r2) ? k2 : 0;
        m_rs_late = h1 && !r1 && !m_stall;
        m_rt_late = h2 && !r2 && !m_stall;
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tab, input bit rst);
        apply(v);
        if (rst) begin
            reset_n = 1'b0;
            for (int i = 0; i <= cyc; i++) ent[i] = bub;
        end
        @(negedge clk);
        model();
        chk("stall", int'(stall), m_stall);
        chk("rs_sel", int'(fwd_rs_sel), m_rs_sel);
        chk("rs_late", int'(fwd_rs_late), m_rs_late);
        chk("rt_sel", int'(fwd_rt_sel), m_rt_sel);
        chk("rt_late", int'(fwd_rt_late), m_rt_late);
        chk("md_busy", int'(md_busy), m_busy);
        if (use_tab) begin
            chk("tab_stall", int'(stall), v.x_stall);
            chk("tab_rs_sel", int'(fwd_rs_sel), v.x_rs_sel);
            chk("tab_rs_late", int'(fwd_rs_late), v.x_rs_late);
            chk("tab_rt_sel", int'(fwd_rt_sel), v.x_rt_sel);
            chk("tab_rt_late", int'(fwd_rt_late), v.x_rt_late);
            chk("tab_md_busy", int'(md_busy), v.x_busy);
        end
        @(posedge clk);
        ent[cyc + 1] = (rst || m_stall) ? bub
                     : '{wen: cur.wen, dst: cur.dst, tnew: int'(cur.tn), md: cur.mds, div: cur.mdd};
        cyc++;
        #1;
        if (rst) reset_n = 1'b1;
    endtask

    initial begin
        vec_t nop, mfhi, v;
        n_chk = 0; n_err = 0; cyc = 8;
        bub = '{wen: 0, dst: 0, tnew: 0, md: 0, div: 0};
        for (int i = 0; i < 2048; i++) ent[i] = bub;
        nop  = mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        mfhi = mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1);
        reset_n = 1'b0;
        apply(nop);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", int'(stall), 0);
        chk("rst_rs_sel", int'(fwd_rs_sel), 0);
        chk("rst_rt_late", int'(fwd_rt_late), 0);
        chk("rst_md_busy", int'(md_busy), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // lw $t0 / addu uses $t0 at t_use=1 / reader sees lw in W
        tab.push_back(mk(29, 1, 0, 3, 8, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(8, 1, 0, 1, 11, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        tab.push_back(mk(8, 1, 0, 1, 11, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0));
        tab.push_back(mk(8, 1, 0, 3, 0, 0, 0, 0, 0, 0,  0, STG_W, 0, 0, 0, 0));
        repeat (3) tab.push_back(nop);
        // addu $t1 / beq on $t1 at t_use=0
        tab.push_back(mk(0, 3, 0, 3, 9, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        tab.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, STG_M, 0, 0, 0, 0));
        tab.push_back(nop);
        // writer of $0 never matches
        tab.push_back(mk(0, 3, 0, 3, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // two ready $t2 producers: youngest wins; then unready youngest over ready older
        tab.push_back(mk(0, 3, 0, 3, 10, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 3, 0, 3, 10, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 3, 10, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, STG_E, 0, 0));
        tab.push_back(mk(0, 3, 0, 3, 10, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 3, 10, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
        tab.push_back(mk(10, 3, 0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        repeat (2) tab.push_back(nop);
        // mult then mfhi: MULT_CYC+1 stall cycles
        tab.push_back(mk(0, 3, 0, 3, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0));
        v = mfhi; v.x_busy = 0; tab.push_back(v);
        repeat (MC) tab.push_back(mfhi);
        v = mfhi; v.x_stall = 0; v.x_busy = 0; tab.push_back(v);
        // div then mfhi: DIV_CYC+1 stall cycles
        tab.push_back(mk(0, 3, 0, 3, 0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0));
        v = mfhi; v.x_busy = 0; tab.push_back(v);
        repeat (DC) tab.push_back(mfhi);
        v = mfhi; v.x_stall = 0; v.x_busy = 0; tab.push_back(v);
        tab.push_back(nop);
        foreach (tab[i]) run_cycle(tab[i], 1'b1, 1'b0);

        // reset asserted in the middle of a load-use stall with HI/LO busy
        run_cycle(mk(0, 3, 0, 3, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        run_cycle(mk(29, 1, 0, 3, 8, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        v = mk(8, 1, 0, 3, 11, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        apply(v);
        @(negedge clk);
        chk("pre_rst_stall", int'(stall), 1);
        chk("pre_rst_busy", int'(md_busy), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_stall", int'(stall), 0);
        chk("mid_rst_busy", int'(md_busy), 0);
        chk("mid_rst_rs_late", int'(fwd_rs_late), 0);
        for (int i = 0; i <= cyc; i++) ent[i] = bub;
        @(posedge clk);
        ent[cyc + 1] = bub;
        cyc++;
        #1 reset_n = 1'b1;
        run_cycle(v, 1'b1, 1'b0);

        // randomized traffic on a small register set so matches are frequent
        for (int n = 0; n < 600; n++) begin
            int regs [4];
            regs = '{0, 8, 9, 10};
            v = mk(regs[$urandom_range(0, 3)], $urandom_range(0, 3), regs[$urandom_range(0, 3)], $urandom_range(0, 3),
                   regs[$urandom_range(0, 3)], $urandom_range(0, 1), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                   0, 0, 0, 0, 0, 0);
            run_cycle(v, 1'b0, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard unit for the five-stage MIPS core, parametrised in tracked pipeline depth and T-field width. It consumes the decoder's per-instruction T_use/T_new fields and holds a shift-register scoreboard of in-flight destination registers. It produces the D-stage stall and forward selects, and owns a HI/LO multiply/divide busy counter. It sits beside the decoder in D and replaces the per-stage comparator glue.

## Interface
- NSTAGE, 3: tracked stages after D (1=E, 2=M, 3=W).
- TW, 2: width of T_use/T_new fields. All-ones T_use means the operand is unused.
- MULT_CYC, 5: busy cycles after a mult enters E.
- DIV_CYC, 10: busy cycles after a div enters E.
- SW = $clog2(NSTAGE+1): forward-select width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- d_rs, d_rt  in  5  D-stage source register numbers.
- d_t_use_rs, d_t_use_rt  in  TW  cycles until each operand is consumed.
- d_dst  in  5  destination register number.
- d_wen  in  1  instruction writes the register file.
- d_t_new  in  TW  cycles after entering E until the result is forwardable.
- d_md_start  in  1  instruction is mult or div.
- d_md_div  in  1  qualifies d_md_start: 1 = div.
- d_md_use  in  1  instruction reads or writes HI/LO (mfhi, mflo, mthi, mtlo, mult, div).
- stall  out  1  freeze F/D and inject a bubble into E.
- fwd_rs_sel, fwd_rt_sel  out  SW  0 = register file; k = stage k result.
- fwd_rs_late, fwd_rt_late  out  1  the youngest producer is not yet ready; the E/M forward mux must re-forward.
- md_busy  out  1  HI/LO counter is non-zero.

## Operation
- Scoreboard entry k (1..NSTAGE) holds {wen, dst, tnew, md_start}.
- A match on operand X at stage k means all of:
  - wen_k = 1
  - dst_k = d_X
  - d_X ≠ 0
  - d_t_use_X ≠ all-ones
- Data stall: any matching stage k has tnew_k > d_t_use_X.
- HI/LO stall: d_md_use & (md_busy | md_start_1).
- stall is the OR of the data stall and the HI/LO stall. It is combinational on the D inputs and the registered state.
- Forward select: take the youngest (lowest k) match.
  - If its tnew = 0: sel = k, late = 0.
  - If its tnew > 0 and no stall: sel = 0, late = 1.
  - No match: sel = 0, late = 0.
  - Older matches are never selected over a younger one.
- Advance every cycle:
  - Entry k ← entry k-1 for k ≥ 2, with tnew decremented and saturating at 0.
  - Entry 1 ← D fields when stall = 0. When stall = 1, entry 1 ← bubble (wen = 0, md_start = 0).
- md counter:
  - Loads MULT_CYC or DIV_CYC when md_start_1 = 1.
  - Otherwise decrements to 0 and holds there.
  - md_busy = (cnt ≠ 0).
  - The counter is sized $clog2(max(MULT_CYC, DIV_CYC)+1).

## Timing
- On reset (asynchronous): all entries are cleared to wen = 0, tnew = 0, md_start = 0; cnt = 0.
- With no matches, outputs after reset are stall = 0, sel = 0, late = 0, md_busy = 0.
- Reset asserted mid-stall clears the scoreboard. stall deasserts combinationally unless the D inputs still match (they cannot, because all wen = 0).
- Zero-cycle latency from D inputs to stall and sel. The state update is one cycle.
- A load followed by a consumer with t_use = 1 gives exactly one bubble. Consumers with t_use = 0 (beq, jr) get one extra bubble per unready stage.
- Simultaneous events:
  - An md_start in E plus an md_use in D stalls. The counter loads on the same edge.
  - A stalled D instruction never enters E, so it is never double-counted.
- A stage-NSTAGE entry falls off the end each cycle. A W producer with tnew = 0 is selected as sel = NSTAGE.

## Structure
- A shared package hz_pkg holds:
  - T_UNUSED = all-ones
  - the entry struct {wen, dst, tnew, md_start}
  - MULT_CYC/DIV_CYC defaults
  - the stage index constants (E = 1, M = 2, W = 3)
- One natural sub-module, hz_md_counter: load/decrement counter plus busy output.
- The scoreboard shift register and match logic are written as a generate loop over NSTAGE.

## Test plan
- lw $t0 (t_new = 2) then addu rs = $t0 (t_use = 1) → stall = 1 for one cycle. Next cycle stall = 0, fwd_rs_sel = 0, fwd_rs_late = 1. Following cycle the consumer, now in E, sees the producer in W.
- addu $t1 (t_new = 1) then beq rs = $t1 (t_use = 0) → one stall cycle, then fwd_rs_sel = 2, late = 0.
- Producer dst = $0 with wen = 1 followed by a reader of $0 → stall = 0, sel = 0 throughout.
- Producers of $t2 in E (tnew = 0) and M (tnew = 0), then a reader of $t2 → fwd_rt_sel = 1 (youngest match wins).
- mult followed by mfhi → stall held for MULT_CYC+1 cycles (one for the mult in E, then MULT_CYC counting down). Repeat with div: DIV_CYC+1 cycles.
- reset_n low during an lw stall → stall = 0 and md_busy = 0 immediately. The first post-reset instruction sees an empty scoreboard.
